// File: rtl/led_matrix_pkg.sv
// Shared types and defaults for the LED frame serializer.
// Optional feature macro: LED_BRIGHTNESS_EN (adds a per-channel brightness shift helper).
package led_matrix_pkg;

    localparam int PIXEL_BITS       = 24;
    localparam int DEF_BIT_CYCLES   = 15;
    localparam int DEF_RESET_CYCLES = 1000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        TAIL,
        LATCH
    } ser_state_t;

`ifdef LED_BRIGHTNESS_EN
    // Dim each GRB channel independently so one colour cannot bleed into the next.
    function automatic logic [PIXEL_BITS-1:0] scale_pixel(input logic [PIXEL_BITS-1:0] w,
                                                          input logic [2:0]            b);
        return {w[23:16] >> b, w[15:8] >> b, w[7:0] >> b};
    endfunction
`endif

endpackage

// File: rtl/led_frame_serializer_if.sv
// Frame request, pixel memory read port and encoder handshake of the serializer.
// Optional feature macro: LED_BRIGHTNESS_EN (adds the brightness control signal).
interface led_frame_serializer_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [23:0]       rd_data;
    logic              shift;
    logic              serial_in;
    logic              transmit;
`ifdef LED_BRIGHTNESS_EN
    logic [2:0]        brightness;

    modport master (output start, rd_data, shift, brightness,
                    input  busy, done, rd_addr, rd_en, serial_in, transmit);
    modport slave  (input  start, rd_data, shift, brightness,
                    output busy, done, rd_addr, rd_en, serial_in, transmit);
`else
    modport master (output start, rd_data, shift,
                    input  busy, done, rd_addr, rd_en, serial_in, transmit);
    modport slave  (input  start, rd_data, shift,
                    output busy, done, rd_addr, rd_en, serial_in, transmit);
`endif
endinterface

// File: rtl/led_pixel_fetch.sv
// Pixel memory read sequencing: forwards read requests, captures the prefetched word
// one cycle after the strobe, and applies optional brightness scaling.
// Optional feature macro: LED_BRIGHTNESS_EN (adds brightness input).
module led_pixel_fetch
    import led_matrix_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef LED_BRIGHTNESS_EN
    input  logic [2:0]            brightness,
`endif
    input  logic                  req,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [PIXEL_BITS-1:0] rd_data,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic [PIXEL_BITS-1:0] word,
    output logic [PIXEL_BITS-1:0] next_word
);
    logic req_q;

    // Strobe is forced low while reset is held so the memory sees no stray read.
    assign rd_en   = req & ~rst;
    assign rd_addr = addr;

`ifdef LED_BRIGHTNESS_EN
    assign word = scale_pixel(rd_data, brightness);
`else
    assign word = rd_data;
`endif

    // Capture the word that the memory returns one cycle after each strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q     <= 1'b0;
            next_word <= '0;
        end else begin
            req_q <= req;
            if (req_q) begin
                next_word <= word;
            end
        end
    end
endmodule

// File: rtl/led_frame_serializer.sv
// Frame serializer feeding the WS2812B bit encoder: one GRB word per pixel, MSB first.
// Optional feature macro: LED_BRIGHTNESS_EN (brightness scaling in led_pixel_fetch).
//
// state | meaning
// IDLE  | waiting for start
// FETCH | first pixel word arriving from memory
// SEND  | serial_in presents sr[23]; advance on each encoder shift
// TAIL  | last bit still being encoded; transmit held high
// LATCH | transmit low for the latch gap; done on final cycle
module led_frame_serializer
    import led_matrix_pkg::*;
#(
    parameter int NUM_PIXELS   = 64,
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int ADDR_W       = $clog2(NUM_PIXELS)
) (
    input logic                   clk,
    input logic                   rst,
    led_frame_serializer_if.slave bus
);
    localparam int                CNT_W    = $clog2(RESET_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [4:0]        LAST_BIT = 5'(PIXEL_BITS - 1);

    ser_state_t            state, state_n;
    logic [PIXEL_BITS-1:0] sr, word, next_word;
    logic [4:0]            bit_idx;
    logic [ADDR_W-1:0]     pix_idx, fetch_addr;
    logic [CNT_W-1:0]      cnt;
    logic                  fetch_req, busy_q, done_q, transmit_q;

    led_pixel_fetch #(.ADDR_W(ADDR_W)) u_fetch (
        .clk       (clk),
        .rst       (rst),
`ifdef LED_BRIGHTNESS_EN
        .brightness(bus.brightness),
`endif
        .req       (fetch_req),
        .addr      (fetch_addr),
        .rd_data   (bus.rd_data),
        .rd_en     (bus.rd_en),
        .rd_addr   (bus.rd_addr),
        .word      (word),
        .next_word (next_word)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.transmit  = transmit_q;
    assign bus.serial_in = sr[PIXEL_BITS-1];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state plus read requests; the next pixel is prefetched on the shift of bit 0
    // so it is ready 23 bits before it is needed.
    always_comb begin
        state_n    = state;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    fetch_req = 1'b1;
                    state_n   = FETCH;
                end
            end
            FETCH: state_n = SEND;
            SEND: begin
                if (bus.shift) begin
                    if (bit_idx == '0 && pix_idx != LAST_PIX) begin
                        fetch_req  = 1'b1;
                        fetch_addr = pix_idx + 1'b1;
                    end
                    if (bit_idx == LAST_BIT && pix_idx == LAST_PIX) begin
                        state_n = TAIL;
                    end
                end
            end
            TAIL: begin
                if (cnt == CNT_W'(BIT_CYCLES - 2)) state_n = LATCH;
            end
            LATCH: begin
                if (cnt == CNT_W'(RESET_CYCLES - 1)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Shift register, bit/pixel indices, TAIL/LATCH timer and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr         <= '0;
            bit_idx    <= '0;
            pix_idx    <= '0;
            cnt        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            transmit_q <= 1'b0;
        end else begin
            busy_q     <= (state_n != IDLE);
            transmit_q <= (state_n == SEND) || (state_n == TAIL);
            done_q     <= (state == LATCH) && (cnt == CNT_W'(RESET_CYCLES - 2));

            if (state_n != state) begin
                cnt <= '0;
            end else if (state == TAIL || state == LATCH) begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                FETCH: begin
                    sr      <= word;
                    bit_idx <= '0;
                    pix_idx <= '0;
                end
                SEND: begin
                    if (bus.shift) begin
                        if (bit_idx != LAST_BIT) begin
                            sr      <= sr << 1;
                            bit_idx <= bit_idx + 1'b1;
                        end else if (pix_idx != LAST_PIX) begin
                            sr      <= next_word;
                            bit_idx <= '0;
                            pix_idx <= pix_idx + 1'b1;
                        end else begin
                            // Park the line low once the final bit is latched.
                            sr <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_led_frame_serializer.sv
// Bench for led_frame_serializer: 2-pixel frames, WS2812B encoder model, 1-cycle memory.
// Optional feature macro: LED_BRIGHTNESS_EN (adds a dimmed-frame vector).
`timescale 1ns/1ps
module tb_led_frame_serializer;
    localparam int NP = 2;
    localparam int BC = 15;
    localparam int RC = 1000;
    localparam int AW = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_frame_serializer_if #(.ADDR_W(AW)) bus ();

    led_frame_serializer #(
        .NUM_PIXELS  (NP),
        .BIT_CYCLES  (BC),
        .RESET_CYCLES(RC),
        .ADDR_W      (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // Pixel memory with one cycle of read latency.
    logic [23:0] mem [NP];
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    // Encoder model: samples serial_in at each bit boundary while transmit is high and
    // confirms the bit with a shift pulse in the next cycle only if transmit is still up.
    logic enc_active, enc_pend, enc_bit;
    int   enc_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_active <= 1'b0;
            enc_pend   <= 1'b0;
            enc_bit    <= 1'b0;
            enc_cnt    <= 0;
        end else begin
            enc_pend <= 1'b0;
            if (!enc_active) begin
                if (bus.transmit) begin
                    enc_active <= 1'b1;
                    enc_cnt    <= 0;
                    enc_bit    <= bus.serial_in;
                    enc_pend   <= 1'b1;
                end
            end else if (enc_cnt == BC - 1) begin
                if (bus.transmit) begin
                    enc_cnt  <= 0;
                    enc_bit  <= bus.serial_in;
                    enc_pend <= 1'b1;
                end else begin
                    enc_active <= 1'b0;
                end
            end else begin
                enc_cnt <= enc_cnt + 1;
            end
        end
    end
    assign bus.shift = enc_pend & bus.transmit;

    // Scoreboard state.
    logic exp_bits [$];
    int   exp_frames = 0;
    int   frames_started = 0;
    int   done_seen = 0;
    int   tx_run = 0, last_tx_run = 0, low_run = 0, done_low = 0;
    int   cyc = 0, last_shift = -1;
    logic prev_tx = 1'b0;

    // Monitor: pops one expected bit per shift pulse, checks bit spacing and frame timing.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_tx    = 1'b0;
            tx_run     = 0;
            low_run    = 0;
            last_shift = -1;
        end else begin
            if (bus.transmit) begin
                if (!prev_tx) begin
                    tx_run     = 0;
                    last_shift = -1;
                    frames_started++;
                end
                tx_run++;
            end else if (prev_tx) begin
                last_tx_run = tx_run;
                low_run     = 1;
            end else begin
                low_run++;
            end
            prev_tx = bus.transmit;

            if (bus.shift) begin
                if (last_shift >= 0) check("bit_period", cyc - last_shift, BC);
                last_shift = cyc;
                if (exp_bits.size() == 0) begin
                    check("extra_shift", 1, 0);
                end else begin
                    check("serial_bit", enc_bit, exp_bits.pop_front());
                end
            end

            if (bus.done) begin
                done_seen++;
                done_low = low_run;
            end
        end
    end

    task automatic run_frame(input logic [23:0] w0, input logic [23:0] w1,
                             input logic [23:0] e0, input logic [23:0] e1, input bit extra);
        bit got_done;
        mem[0] = w0;
        mem[1] = w1;
        for (int i = 23; i >= 0; i--) exp_bits.push_back(e0[i]);
        for (int i = 23; i >= 0; i--) exp_bits.push_back(e1[i]);
        exp_frames++;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        got_done = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (bus.done) begin
                got_done = 1'b1;
                break;
            end
            bus.start = extra && (c == 200);
        end
        check("done_seen", got_done, 1);
        check("busy_at_done", bus.busy, 1);
        if (extra) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_done", bus.busy, 0);
        check("done_width", bus.done, 0);
        check("tx_high_cycles", last_tx_run, NP * 24 * BC + 1);
        check("latch_gap", done_low, RC);
        check("bits_left", exp_bits.size(), 0);
        if (extra) repeat (40) @(negedge clk);
        check("frame_count", frames_started, exp_frames);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0;
`ifdef LED_BRIGHTNESS_EN
        bus.brightness = 3'd0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_rd_en", bus.rd_en, 0);
        check("rst_serial_in", bus.serial_in, 0);
        check("rst_transmit", bus.transmit, 0);
        check("rst_rd_addr", bus.rd_addr, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        run_frame(24'hFF0000, 24'h00AA55, 24'hFF0000, 24'h00AA55, 1'b0);
        run_frame(24'h123456, 24'hABCDEF, 24'h123456, 24'hABCDEF, 1'b1);
        run_frame(24'h800001, 24'h7FFFFE, 24'h800001, 24'h7FFFFE, 1'b0);

        // Reset in the middle of an all-ones frame.
        mem[0] = 24'hFFFFFF;
        mem[1] = 24'hFFFFFF;
        for (int i = 0; i < 48; i++) exp_bits.push_back(1'b1);
        exp_frames++;
        done_seen = 0;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        repeat (100) @(negedge clk);
        check("pre_rst_transmit", bus.transmit, 1);
        check("pre_rst_serial_in", bus.serial_in, 1);
        check("pre_rst_busy", bus.busy, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_transmit", bus.transmit, 0);
        check("midrst_serial_in", bus.serial_in, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_rd_en", bus.rd_en, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_bits.delete();
        repeat (1200) @(negedge clk);
        check("midrst_no_done", done_seen, 0);
        check("midrst_frame_count", frames_started, exp_frames);

        run_frame(24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A, 1'b0);

`ifdef LED_BRIGHTNESS_EN
        bus.brightness = 3'd2;
        run_frame(24'hFF8040, 24'h000000, 24'h3F2010, 24'h000000, 1'b0);
        bus.brightness = 3'd0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
